// File: rtl/tcpc_rx_msg_if.sv
// PHY receive stream into the TCPC RX message engine: frame delimiters,
// byte strobe, CRC verdict and the Hard Reset ordered-set detect.
interface tcpc_rx_msg_if;
  logic       sop;
  logic [2:0] frame_type;
  logic       valid;
  logic [7:0] rx_byte;
  logic       eop;
  logic       crc_ok;
  logic       hard_reset;

  modport master (output sop, frame_type, valid, rx_byte, eop, crc_ok, hard_reset);
  modport slave  (input  sop, frame_type, valid, rx_byte, eop, crc_ok, hard_reset);
endinterface

// File: rtl/tcpc_rx_msg.sv
// TCPC receive-path message engine. Stages an inbound PHY frame, validates
// type enable, CRC and length, requests GoodCRC from the TX block, and commits
// accepted messages into the RX buffer registers read by the TCPM.
// Optional build macro RX_DISCARD_DUP_EN: remember MessageID and frame type of
// the last committed message; a matching retransmission is acknowledged but
// not committed again.
module tcpc_rx_msg #(
  parameter int MAX_BYTES   = 30,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  tcpc_rx_msg_if.slave               phy,
  input  logic [7:0]                 receive_detect,
  input  logic                       alert_rx_clear,
  input  logic                       good_crc_ack,
  output logic                       good_crc_request,
  output logic                       good_crc_response,
  output logic [7:0]                 rx_buf_frame_type,
  output logic [7:0]                 rx_buf_header_byte_0,
  output logic [7:0]                 rx_buf_header_byte_1,
  output logic [8*(MAX_BYTES-2)-1:0] rx_buf_data_objects,
  output logic [7:0]                 rx_buf_byte_count,
  output logic                       alert_received_sop_message_status,
  output logic                       alert_rx_buffer_overflow,
  output logic                       alert_received_hard_reset
);

  localparam int DATA_BYTES = MAX_BYTES - 2;
  localparam int CW         = $clog2(MAX_BYTES + 1);
  localparam int TW         = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_CHECK, S_ACK, S_DROP} state_t;

  state_t         state_q, state_d;

  // Staging: bytes of the frame in flight plus its attributes.
  logic [7:0]     stage_mem [MAX_BYTES];
  logic [CW-1:0]  cnt_q;
  logic [2:0]     ftype_q;
  logic           crc_ok_q;
  logic           dup_q;
  logic [TW-1:0]  ack_tmr_q;

  logic [2:0]     ndo;
  logic           frame_ok, is_good_crc, is_dup, ack_expired;
  logic           frame_start, byte_wr, eop_seen, enter_ack, commit, set_ovf, set_resp;

  assign ndo         = stage_mem[1][6:4];
  assign frame_ok    = crc_ok_q && receive_detect[ftype_q] && (cnt_q >= CW'(2)) &&
                       ((cnt_q - CW'(2)) == CW'({ndo, 2'b00}));
  assign is_good_crc = (stage_mem[0][4:0] == 5'b00001) && (ndo == 3'd0);
  assign ack_expired = (ack_tmr_q == TW'(ACK_TIMEOUT - 1));

  assign good_crc_request = (state_q == S_ACK);

`ifdef RX_DISCARD_DUP_EN
  logic [2:0] last_id_q;
  logic [2:0] last_type_q;
  logic       last_vld_q;

  assign is_dup = last_vld_q && (last_id_q == stage_mem[1][3:1]) && (last_type_q == ftype_q);

  // Remember identity of the last committed message; forgotten on hard reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id_q   <= '0;
      last_type_q <= '0;
      last_vld_q  <= 1'b0;
    end else if (phy.hard_reset) begin
      last_id_q   <= '0;
      last_type_q <= '0;
      last_vld_q  <= 1'b0;
    end else if (commit) begin
      last_id_q   <= stage_mem[1][3:1];
      last_type_q <= ftype_q;
      last_vld_q  <= 1'b1;
    end
  end
`else
  assign is_dup = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state and datapath registers use <= so every flop samples pre-edge values.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and single-cycle datapath strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d     = state_q;
    frame_start = 1'b0;
    byte_wr     = 1'b0;
    eop_seen    = 1'b0;
    enter_ack   = 1'b0;
    commit      = 1'b0;
    set_ovf     = 1'b0;
    set_resp    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (phy.sop) begin
          frame_start = 1'b1;
          state_d     = S_RECV;
        end
      end
      S_RECV: begin
        if (phy.sop) begin
          frame_start = 1'b1;
        end else if (phy.valid && (cnt_q == CW'(MAX_BYTES))) begin
          // Oversized frame: if it also ends here there is no EOP left to wait for.
          state_d = phy.eop ? S_IDLE : S_DROP;
        end else begin
          byte_wr = phy.valid;
          if (phy.eop) begin
            eop_seen = 1'b1;
            state_d  = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if (frame_ok) begin
          if (is_good_crc) begin
            set_resp = 1'b1;
          end else if (is_dup || !alert_received_sop_message_status) begin
            enter_ack = 1'b1;
            state_d   = S_ACK;
          end else begin
            set_ovf = 1'b1;
          end
        end
      end
      S_ACK: begin
        if (good_crc_ack) begin
          commit  = !dup_q;
          state_d = S_IDLE;
        end else if (ack_expired) begin
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (phy.eop) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (phy.hard_reset) state_d = S_IDLE;
  end

  // Staging, RX buffer commit and alert flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: staging memory is reset explicitly because it must read as zero after reset.
      for (int i = 0; i < MAX_BYTES; i++) stage_mem[i] <= '0;
      cnt_q                             <= '0;
      ftype_q                           <= '0;
      crc_ok_q                          <= 1'b0;
      dup_q                             <= 1'b0;
      ack_tmr_q                         <= '0;
      good_crc_response                 <= 1'b0;
      rx_buf_frame_type                 <= '0;
      rx_buf_header_byte_0              <= '0;
      rx_buf_header_byte_1              <= '0;
      rx_buf_data_objects               <= '0;
      rx_buf_byte_count                 <= '0;
      alert_received_sop_message_status <= 1'b0;
      alert_rx_buffer_overflow          <= 1'b0;
      alert_received_hard_reset         <= 1'b0;
    end else if (phy.hard_reset) begin
      for (int i = 0; i < MAX_BYTES; i++) stage_mem[i] <= '0;
      cnt_q                             <= '0;
      ftype_q                           <= '0;
      crc_ok_q                          <= 1'b0;
      dup_q                             <= 1'b0;
      ack_tmr_q                         <= '0;
      good_crc_response                 <= 1'b0;
      rx_buf_frame_type                 <= '0;
      rx_buf_header_byte_0              <= '0;
      rx_buf_header_byte_1              <= '0;
      rx_buf_data_objects               <= '0;
      rx_buf_byte_count                 <= '0;
      alert_received_sop_message_status <= 1'b0;
      alert_rx_buffer_overflow          <= 1'b0;
      alert_received_hard_reset         <= 1'b1;
    end else begin
      alert_received_hard_reset <= 1'b0;
      good_crc_response         <= set_resp;

      if (frame_start) begin
        cnt_q   <= '0;
        ftype_q <= phy.frame_type;
      end else if (byte_wr) begin
        stage_mem[cnt_q] <= phy.rx_byte;
        cnt_q            <= cnt_q + CW'(1);
      end
      if (eop_seen) crc_ok_q <= phy.crc_ok;

      if (enter_ack) begin
        dup_q     <= is_dup;
        ack_tmr_q <= '0;
      end else if (state_q == S_ACK) begin
        ack_tmr_q <= ack_tmr_q + TW'(1);
      end

      if (commit) begin
        rx_buf_frame_type    <= {5'b0, ftype_q};
        rx_buf_header_byte_0 <= stage_mem[0];
        rx_buf_header_byte_1 <= stage_mem[1];
        rx_buf_byte_count    <= 8'(cnt_q) + 8'd1;
        for (int k = 0; k < DATA_BYTES; k++) rx_buf_data_objects[8*k +: 8] <= stage_mem[k+2];
      end

      // A commit beats a simultaneous clear; a lost message beats a clear.
      if (commit)              alert_received_sop_message_status <= 1'b1;
      else if (alert_rx_clear) alert_received_sop_message_status <= 1'b0;
      if (set_ovf)             alert_rx_buffer_overflow <= 1'b1;
      else if (alert_rx_clear) alert_rx_buffer_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tcpc_rx_msg.sv
// Self-checking bench for tcpc_rx_msg: directed frames from the test plan
// followed by randomized frames, compared against a message-level model.
module tb_tcpc_rx_msg;

  localparam int MAX_BYTES   = 30;
  localparam int ACK_TIMEOUT = 255;
  localparam int DBITS       = 8 * (MAX_BYTES - 2);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tcpc_rx_msg_if phy ();

  logic [7:0]       receive_detect;
  logic             alert_rx_clear;
  logic             good_crc_ack;
  logic             good_crc_request;
  logic             good_crc_response;
  logic [7:0]       rx_buf_frame_type;
  logic [7:0]       rx_buf_header_byte_0;
  logic [7:0]       rx_buf_header_byte_1;
  logic [DBITS-1:0] rx_buf_data_objects;
  logic [7:0]       rx_buf_byte_count;
  logic             alert_received_sop_message_status;
  logic             alert_rx_buffer_overflow;
  logic             alert_received_hard_reset;

  tcpc_rx_msg #(.MAX_BYTES(MAX_BYTES), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk                               (clk),
    .rst_n                             (rst_n),
    .phy                               (phy),
    .receive_detect                    (receive_detect),
    .alert_rx_clear                    (alert_rx_clear),
    .good_crc_ack                      (good_crc_ack),
    .good_crc_request                  (good_crc_request),
    .good_crc_response                 (good_crc_response),
    .rx_buf_frame_type                 (rx_buf_frame_type),
    .rx_buf_header_byte_0              (rx_buf_header_byte_0),
    .rx_buf_header_byte_1              (rx_buf_header_byte_1),
    .rx_buf_data_objects               (rx_buf_data_objects),
    .rx_buf_byte_count                 (rx_buf_byte_count),
    .alert_received_sop_message_status (alert_received_sop_message_status),
    .alert_rx_buffer_overflow          (alert_rx_buffer_overflow),
    .alert_received_hard_reset         (alert_received_hard_reset)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [DBITS-1:0] got, input logic [DBITS-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Message-level model of what the TCPM should see.
  bit               m_status, m_ovf;
  logic [7:0]       m_type, m_h0, m_h1, m_count;
  logic [DBITS-1:0] m_data, m_mask;
  bit               m_last_vld;
  logic [2:0]       m_last_id, m_last_type;

  function automatic void model_clear_all();
    m_status   = 0;
    m_ovf      = 0;
    m_type     = '0;
    m_h0       = '0;
    m_h1       = '0;
    m_count    = '0;
    m_data     = '0;
    m_mask     = '1;
    m_last_vld = 0;
  endfunction

  task automatic check_buf(input string tag);
    check({tag, "_status"}, DBITS'(alert_received_sop_message_status), DBITS'(m_status));
    check({tag, "_ovf"},    DBITS'(alert_rx_buffer_overflow), DBITS'(m_ovf));
    check({tag, "_type"},   DBITS'(rx_buf_frame_type), DBITS'(m_type));
    check({tag, "_hdr0"},   DBITS'(rx_buf_header_byte_0), DBITS'(m_h0));
    check({tag, "_hdr1"},   DBITS'(rx_buf_header_byte_1), DBITS'(m_h1));
    check({tag, "_count"},  DBITS'(rx_buf_byte_count), DBITS'(m_count));
    check({tag, "_data"},   rx_buf_data_objects & m_mask, m_data);
  endtask

  task automatic send_frame(input logic [2:0] ft, input logic [7:0] b[$], input bit crc, input bit eop_sep);
    @(posedge clk); #1;
    phy.sop        = 1'b1;
    phy.frame_type = ft;
    @(posedge clk); #1;
    phy.sop = 1'b0;
    for (int i = 0; i < b.size(); i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
      phy.valid   = 1'b1;
      phy.rx_byte = b[i];
      if (i == b.size() - 1 && !eop_sep) begin
        phy.eop    = 1'b1;
        phy.crc_ok = crc;
      end
      @(posedge clk); #1;
      phy.valid  = 1'b0;
      phy.eop    = 1'b0;
      phy.crc_ok = 1'b0;
    end
    if (eop_sep || b.size() == 0) begin
      phy.eop    = 1'b1;
      phy.crc_ok = crc;
      @(posedge clk); #1;
      phy.eop    = 1'b0;
      phy.crc_ok = 1'b0;
    end
  endtask

  // Act as the TX block: ack after ack_after request cycles (0 = never).
  task automatic respond(input int ack_after, output int req_c, output int resp_c, output bit hung);
    req_c  = 0;
    resp_c = 0;
    hung   = 1;
    for (int i = 0; i < ACK_TIMEOUT + 16; i++) begin
      @(negedge clk);
      if (good_crc_response) resp_c++;
      if (good_crc_request) begin
        req_c++;
        good_crc_ack = (req_c == ack_after);
      end else begin
        good_crc_ack = 1'b0;
        if (req_c > 0 || i >= 3) begin
          hung = 0;
          break;
        end
      end
    end
    good_crc_ack = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [2:0] ft, input logic [7:0] b[$],
                           input bit crc, input int ack_after, input bit eop_sep);
    int         req_c, resp_c, len, exp_req, exp_resp;
    bit         hung, valid, dup;
    logic [7:0] h0, h1;
    len      = b.size();
    h0       = (len >= 1) ? b[0] : 8'h00;
    h1       = (len >= 2) ? b[1] : 8'h00;
    exp_req  = 0;
    exp_resp = 0;
    send_frame(ft, b, crc, eop_sep);
    respond(ack_after, req_c, resp_c, hung);

    valid = crc && receive_detect[ft] && len >= 2 && len <= MAX_BYTES &&
            (len - 2) == 4 * int'(h1[6:4]);
    if (valid) begin
      dup = 0;
`ifdef RX_DISCARD_DUP_EN
      dup = m_last_vld && m_last_id == h1[3:1] && m_last_type == ft;
`endif
      if (h0[4:0] == 5'b00001 && h1[6:4] == 3'd0) begin
        exp_resp = 1;
      end else if (dup || !m_status) begin
        exp_req = (ack_after > 0) ? ack_after : ACK_TIMEOUT;
        if (ack_after > 0 && !dup) begin
          m_status    = 1;
          m_type      = {5'b0, ft};
          m_h0        = h0;
          m_h1        = h1;
          m_count     = 8'(len + 1);
          m_data      = '0;
          m_mask      = '0;
          for (int k = 0; k < len - 2; k++) begin
            m_data[8*k +: 8] = b[k+2];
            m_mask[8*k +: 8] = 8'hff;
          end
          m_last_vld  = 1;
          m_last_id   = h1[3:1];
          m_last_type = ft;
        end
      end else begin
        m_ovf = 1;
      end
    end
    check({tag, "_bound"}, DBITS'(hung), DBITS'(0));
    check({tag, "_req"},   DBITS'(req_c), DBITS'(exp_req));
    check({tag, "_resp"},  DBITS'(resp_c), DBITS'(exp_resp));
    check_buf(tag);
  endtask

  task automatic clear_alerts();
    @(posedge clk); #1;
    alert_rx_clear = 1'b1;
    @(posedge clk); #1;
    alert_rx_clear = 1'b0;
    m_status = 0;
    m_ovf    = 0;
    @(negedge clk);
    check("clr_status", DBITS'(alert_received_sop_message_status), DBITS'(0));
    check("clr_ovf",    DBITS'(alert_rx_buffer_overflow), DBITS'(0));
  endtask

  task automatic hard_reset_mid(input int nbytes);
    @(posedge clk); #1;
    phy.sop        = 1'b1;
    phy.frame_type = 3'd0;
    @(posedge clk); #1;
    phy.sop = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      phy.valid   = 1'b1;
      phy.rx_byte = 8'($urandom);
      @(posedge clk); #1;
      phy.valid = 1'b0;
    end
    phy.hard_reset = 1'b1;
    @(posedge clk); #1;
    phy.hard_reset = 1'b0;
    @(negedge clk);
    check("hr_pulse", DBITS'(alert_received_hard_reset), DBITS'(1));
    @(negedge clk);
    check("hr_pulse_end", DBITS'(alert_received_hard_reset), DBITS'(0));
    model_clear_all();
    check_buf("hr");
  endtask

  task automatic random_frame(input int idx);
    logic [7:0] q[$];
    logic [7:0] h0, h1;
    logic [2:0] ft;
    int         ndo, len, r, ack_after;
    ft  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
    ndo = $urandom_range(0, 7);
    h0  = 8'($urandom);
    if ($urandom_range(0, 4) == 0) h0[4:0] = 5'b00001;
    h1  = {1'($urandom), 3'(ndo), 3'($urandom_range(0, 1)), 1'($urandom)};
    len = 2 + 4 * ndo;
    r   = $urandom_range(0, 9);
    if (r == 0)      len = ($urandom_range(0, 1) == 1) ? len + 1 : len - 1;
    else if (r == 1) len = $urandom_range(MAX_BYTES + 1, MAX_BYTES + 4);
    q.push_back(h0);
    if (len >= 2) q.push_back(h1);
    for (int i = 2; i < len; i++) q.push_back(8'($urandom));
    ack_after = ($urandom_range(0, 39) == 0) ? 0 : $urandom_range(1, 6);
    run_frame($sformatf("rnd%0d", idx), ft, q, $urandom_range(0, 7) != 0, ack_after,
              1'($urandom));
  endtask

  initial begin
    logic [7:0] q[$];
    rst_n          = 1'b0;
    phy.sop        = 1'b0;
    phy.frame_type = 3'd0;
    phy.valid      = 1'b0;
    phy.rx_byte    = 8'h00;
    phy.eop        = 1'b0;
    phy.crc_ok     = 1'b0;
    phy.hard_reset = 1'b0;
    receive_detect = 8'hff;
    alert_rx_clear = 1'b0;
    good_crc_ack   = 1'b0;
    model_clear_all();

    repeat (3) @(negedge clk);
    check("rst_req",  DBITS'(good_crc_request), DBITS'(0));
    check("rst_resp", DBITS'(good_crc_response), DBITS'(0));
    check("rst_hr",   DBITS'(alert_received_hard_reset), DBITS'(0));
    check_buf("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Normal message, ack after 3 request cycles.
    q = '{8'h41, 8'h10, 8'haa, 8'hbb, 8'hcc, 8'hdd};
    run_frame("tp1", 3'd0, q, 1'b1, 3, 1'b0);
    check("tp1_count_abs", DBITS'(rx_buf_byte_count), DBITS'(7));
    check("tp1_do_abs", DBITS'(rx_buf_data_objects[31:0]), DBITS'(32'hddccbbaa));

    // Inbound GoodCRC.
    q = '{8'h01, 8'h02};
    run_frame("tp2", 3'd0, q, 1'b1, 3, 1'b0);

    // Second message while buffer full -> overflow.
    q = '{8'h42, 8'h12, 8'h11, 8'h22, 8'h33, 8'h44};
    run_frame("tp3", 3'd1, q, 1'b1, 2, 1'b1);
    check("tp3_ovf_abs", DBITS'(alert_rx_buffer_overflow), DBITS'(1));
    clear_alerts();

    // Rejected frames: bad CRC, type disabled, too long.
    q = '{8'h43, 8'h14, 8'h01, 8'h02, 8'h03, 8'h04};
    run_frame("tp4_crc", 3'd0, q, 1'b0, 2, 1'b0);
    receive_detect = 8'h00;
    run_frame("tp4_rd", 3'd0, q, 1'b1, 2, 1'b0);
    receive_detect = 8'hff;
    q = {};
    q.push_back(8'h44);
    q.push_back(8'h70);
    for (int i = 0; i < 29; i++) q.push_back(8'(i));
    run_frame("tp4_long", 3'd0, q, 1'b1, 2, 1'b0);

    // No ack: request must time out.
    q = '{8'h45, 8'h16, 8'h55, 8'h66, 8'h77, 8'h88};
    run_frame("tp5_to", 3'd0, q, 1'b1, 0, 1'b0);

    // Maximum-length message accepted.
    q = {};
    q.push_back(8'h46);
    q.push_back(8'h78);
    for (int i = 0; i < 28; i++) q.push_back(8'($urandom));
    run_frame("tp_max", 3'd2, q, 1'b1, 1, 1'b0);
    clear_alerts();

    hard_reset_mid(3);

    // Same MessageID twice, then again after clear.
    q = '{8'h47, 8'h1a, 8'h01, 8'h23, 8'h45, 8'h67};
    run_frame("tp6_a", 3'd0, q, 1'b1, 2, 1'b0);
    run_frame("tp6_b", 3'd0, q, 1'b1, 2, 1'b0);
    clear_alerts();
    run_frame("tp6_c", 3'd0, q, 1'b1, 2, 1'b0);
    clear_alerts();

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 14) == 0) receive_detect = 8'($urandom);
      else                            receive_detect = 8'hff;
      if ($urandom_range(0, 29) == 0) hard_reset_mid($urandom_range(0, 5));
      random_frame(n);
      if ($urandom_range(0, 2) == 0) clear_alerts();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
